rs_alu_station: RTL
===================

Name: rs_alu_station

Overview:
- Reservation station for the integer ALU path; sits directly upstream of the ALU and drives its ALU_S/Op/Vj/Vk/Reorder/A/pc inputs.
- Accepts one decoded instruction per cycle from dispatch.
- Snoops the ALU and LSB result buses to wake up waiting operands.
- Issues at most one operand-ready entry per cycle to the ALU through a registered output stage.

Parameters:
RS_SIZE, 16, number of entries (power of two, 2..32)
ROB_W, 4, reorder-buffer tag width
OP_W, 6, internal opcode width (matches ALU Op encoding)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze all state
clr  in  1  mispredict flush
disp_valid  in  1  dispatch request this cycle
disp_op  in  OP_W  opcode
disp_vj  in  32  operand j value (valid when disp_qj_busy=0)
disp_qj_busy  in  1  operand j pending
disp_qj  in  ROB_W  ROB tag producing operand j
disp_vk  in  32  operand k value
disp_qk_busy  in  1  operand k pending
disp_qk  in  ROB_W  ROB tag producing operand k
disp_a  in  32  immediate
disp_pc  in  32  instruction pc
disp_rob  in  ROB_W  destination ROB tag
rs_full  out  1  no free entry
cdb_alu_s  in  1  ALU result bus valid
cdb_alu_rob  in  ROB_W  ALU result tag
cdb_alu_value  in  32  ALU result
cdb_lsb_s  in  1  LSB result bus valid
cdb_lsb_rob  in  ROB_W  LSB result tag
cdb_lsb_value  in  32  LSB result
alu_s  out  1  issue valid to ALU
alu_op  out  OP_W  issued opcode
alu_vj  out  32  issued operand j
alu_vk  out  32  issued operand k
alu_reorder  out  ROB_W  issued ROB tag
alu_a  out  32  issued immediate
alu_pc  out  32  issued pc

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high.
- Reset or clr at an edge: every entry busy=0; alu_s=0.
- Reset only: all alu_* data outputs = 0.
- After reset or clr, rs_full=0.
- rdy=0 (rst/clr low): all entries and outputs hold; CDB and dispatch inputs ignored.
- Entry state: busy, op, vj, qj_busy, qj, vk, qk_busy, qk, a, pc, rob.
- rs_full: combinational; 1 iff all RS_SIZE entries are busy in registered state.
- Dispatch (disp_valid=1 and rs_full=0):
  - Writes the lowest-index non-busy entry, using pre-edge busy state.
  - An entry freed by issue in the same cycle is not reusable until the next cycle.
  - disp_valid with rs_full=1 is dropped; upstream must not do this.
- Dispatch-cycle forwarding: if disp_qj_busy=1 and a CDB bus is valid with tag == disp_qj in the same cycle, store the bus value with qj_busy=0. Same rule for k.
- Wake-up: each cycle, every busy entry with qj_busy=1 and a valid CDB tag == qj latches that value and clears qj_busy. Same rule for k.
- If both buses match the same tag, the ALU bus wins; this is not expected, since ROB tags are unique.
- Ready entry: busy && !qj_busy && !qk_busy, evaluated on registered state only.
  - An operand woken at edge t makes its entry eligible for selection in the cycle after t.
- Issue:
  - Select the lowest-index ready entry.
  - At the edge: alu_s=1, alu_* loaded from the entry, entry busy=0.
  - No ready entry: alu_s=0 and data outputs hold their last values.
  - At most one issue per cycle.
- Latency:
  - Dispatch with both operands ready at edge t → earliest alu_s=1 after edge t+1.
  - Operand woken at edge t → earliest issue after edge t+1.
- Simultaneous dispatch, wake-up and issue in one cycle are all legal and independent.
- clr has priority over dispatch, wake-up and issue in the same cycle.
- Reset mid-operation discards all entries with no issue.
- Tags are not checked against ROB validity; flush is handled only through clr.

Test Plan:
- Reset, then dispatch ADD (vj=5, vk=7, rob=3, both ready) at edge 1 → alu_s=1 after edge 2 with alu_vj=5, alu_vk=7, alu_reorder=3; alu_s=0 after edge 3.
- Dispatch ADDI with qj_busy=1, qj=2; three cycles later cdb_alu_s=1, cdb_alu_rob=2, cdb_alu_value=0x10 → alu_s=1 one edge after the wake-up edge, alu_vj=0x10.
- Dispatch with qk=5 in the same cycle cdb_lsb_s=1, cdb_lsb_rob=5, value=0xABCD → entry stored ready; issues next cycle with alu_vk=0xABCD.
- Fill all 16 entries with qj pending on tag 7 → rs_full=1; extra dispatch dropped; broadcast tag 7 → 16 consecutive issues in index order, rs_full=0 after the first issue edge.
- Two entries ready plus a new dispatch in one cycle → lower index issues, new entry lands in the lowest non-busy slot (not the slot being freed).
- Pending entries, then clr=1 for one cycle → alu_s=0, rs_full=0, no later issue even when the matching CDB tags broadcast; rdy=0 for 3 cycles mid-stream → outputs and entries frozen, issue resumes unchanged.

Source files
------------

// File: rtl/rs_alu_station.sv
// ALU reservation station: buffers dispatched ops, snoops ALU/LSB result buses, and issues
// the lowest-index operand-ready entry each cycle through a registered output stage.
module rs_alu_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_vj,
  input  logic             disp_qj_busy,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qk_busy,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic [31:0]      disp_a,
  input  logic [31:0]      disp_pc,
  input  logic [ROB_W-1:0] disp_rob,
  output logic             rs_full,
  input  logic             cdb_alu_s,
  input  logic [ROB_W-1:0] cdb_alu_rob,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_s,
  input  logic [ROB_W-1:0] cdb_lsb_rob,
  input  logic [31:0]      cdb_lsb_value,
  output logic             alu_s,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_vj,
  output logic [31:0]      alu_vk,
  output logic [ROB_W-1:0] alu_reorder,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_pc
);

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [OP_W-1:0]    op  [RS_SIZE];
  logic [31:0]        vj  [RS_SIZE];
  logic [31:0]        vk  [RS_SIZE];
  logic [ROB_W-1:0]   qj  [RS_SIZE];
  logic [ROB_W-1:0]   qk  [RS_SIZE];
  logic [31:0]        a   [RS_SIZE];
  logic [31:0]        pc  [RS_SIZE];
  logic [ROB_W-1:0]   rob [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic               iss_found;
  logic [IDX_W-1:0]   iss_idx;
  logic [IDX_W-1:0]   free_idx;
  logic               dj_busy, dk_busy;
  logic [31:0]        dj_val, dk_val;

  assign ready   = busy & ~qj_busy & ~qk_busy;
  assign rs_full = &busy;

  // Both encoders look only at registered state, so a slot freed by issue this cycle stays unavailable.
  always_comb begin
    iss_found = 1'b0;
    iss_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
      if (!busy[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // Capture a result broadcast in the same cycle the dependent op is dispatched.
  always_comb begin
    dj_busy = disp_qj_busy;
    dj_val  = disp_vj;
    if (disp_qj_busy && cdb_alu_s && cdb_alu_rob == disp_qj) begin
      dj_busy = 1'b0;
      dj_val  = cdb_alu_value;
    end else if (disp_qj_busy && cdb_lsb_s && cdb_lsb_rob == disp_qj) begin
      dj_busy = 1'b0;
      dj_val  = cdb_lsb_value;
    end
    dk_busy = disp_qk_busy;
    dk_val  = disp_vk;
    if (disp_qk_busy && cdb_alu_s && cdb_alu_rob == disp_qk) begin
      dk_busy = 1'b0;
      dk_val  = cdb_alu_value;
    end else if (disp_qk_busy && cdb_lsb_s && cdb_lsb_rob == disp_qk) begin
      dk_busy = 1'b0;
      dk_val  = cdb_lsb_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      alu_s       <= 1'b0;
      alu_op      <= '0;
      alu_vj      <= '0;
      alu_vk      <= '0;
      alu_reorder <= '0;
      alu_a       <= '0;
      alu_pc      <= '0;
    end else if (clr) begin
      busy  <= '0;
      alu_s <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && qj_busy[i]) begin
          if (cdb_alu_s && cdb_alu_rob == qj[i]) begin
            vj[i]      <= cdb_alu_value;
            qj_busy[i] <= 1'b0;
          end else if (cdb_lsb_s && cdb_lsb_rob == qj[i]) begin
            vj[i]      <= cdb_lsb_value;
            qj_busy[i] <= 1'b0;
          end
        end
        if (busy[i] && qk_busy[i]) begin
          if (cdb_alu_s && cdb_alu_rob == qk[i]) begin
            vk[i]      <= cdb_alu_value;
            qk_busy[i] <= 1'b0;
          end else if (cdb_lsb_s && cdb_lsb_rob == qk[i]) begin
            vk[i]      <= cdb_lsb_value;
            qk_busy[i] <= 1'b0;
          end
        end
      end

      alu_s <= iss_found;
      if (iss_found) begin
        busy[iss_idx] <= 1'b0;
        alu_op        <= op[iss_idx];
        alu_vj        <= vj[iss_idx];
        alu_vk        <= vk[iss_idx];
        alu_reorder   <= rob[iss_idx];
        alu_a         <= a[iss_idx];
        alu_pc        <= pc[iss_idx];
      end

      if (disp_valid && !rs_full) begin
        busy[free_idx]    <= 1'b1;
        op[free_idx]      <= disp_op;
        vj[free_idx]      <= dj_val;
        qj_busy[free_idx] <= dj_busy;
        qj[free_idx]      <= disp_qj;
        vk[free_idx]      <= dk_val;
        qk_busy[free_idx] <= dk_busy;
        qk[free_idx]      <= disp_qk;
        a[free_idx]       <= disp_a;
        pc[free_idx]      <= disp_pc;
        rob[free_idx]     <= disp_rob;
      end
    end
  end

endmodule
